// File: rtl/demux2_stream.sv
// ----------------------------------------------------------------------------
// demux2_stream
// Two-way valid/ready stream demultiplexer. Each accepted input word is routed
// to output channel 0 or 1, either by an explicit select or by an alternating
// burst pattern (BURST_LEN consecutive words per channel). Each output channel
// owns a one-entry holding register, so a stalled lane never loses or corrupts
// data, and a channel sustains one word per cycle when its consumer is ready.
//
// Parameters
//   SIZE       data word width in bits (>= 1)
//   BURST_LEN  auto-mode words per channel before switching (>= 1)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   auto_mode   1 = alternating-burst routing, 0 = route by sel
//   sel         explicit target channel when auto_mode = 0
//   in_data     input word
//   in_valid    input word present
//   in_ready    input word accepted when in_valid & in_ready
//   out0_data   channel 0 word            out1_data   channel 1 word
//   out0_valid  channel 0 register full   out1_valid  channel 1 register full
//   out0_ready  channel 0 consumer ready  out1_ready  channel 1 consumer ready
//   busy        out0_valid | out1_valid
// ----------------------------------------------------------------------------
module demux2_stream #(
   parameter int unsigned SIZE      = 4,
   parameter int unsigned BURST_LEN = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            auto_mode,
   input  logic            sel,
   input  logic [SIZE-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SIZE-1:0] out0_data,
   output logic            out0_valid,
   input  logic            out0_ready,
   output logic [SIZE-1:0] out1_data,
   output logic            out1_valid,
   input  logic            out1_ready,
   output logic            busy
);

   localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   // Holding registers and burst state
   logic [SIZE-1:0]  data0_q, data0_d;
   logic [SIZE-1:0]  data1_q, data1_d;
   logic             valid0_q, valid0_d;
   logic             valid1_q, valid1_d;
   logic             rr_ch_q, rr_ch_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             busy_q, busy_d;

   // Handshake decode
   logic tgt;
   logic tgt_stalled;
   logic accept;
   logic load0, load1;
   logic drain0, drain1;

   // Target channel: burst pointer in auto mode, otherwise the explicit select
   assign tgt = auto_mode ? rr_ch_q : sel;

   // The target can take a word if it is empty or is draining this cycle;
   // the other channel's state is deliberately ignored (no bypass).
   assign tgt_stalled = tgt ? (valid1_q & ~out1_ready)
                            : (valid0_q & ~out0_ready);

   assign in_ready = rst_n & ~tgt_stalled;
   assign accept   = in_valid & in_ready;
   assign load0    = accept & ~tgt;
   assign load1    = accept &  tgt;
   assign drain0   = valid0_q & out0_ready;
   assign drain1   = valid1_q & out1_ready;

   // Channel 0 next state: a load overrides a same-cycle drain
   always_comb begin
      data0_d  = data0_q;
      valid0_d = valid0_q;
      if (drain0) begin
         valid0_d = 1'b0;
      end
      if (load0) begin
         valid0_d = 1'b1;
         data0_d  = in_data;
      end
   end

   // Channel 1 next state: a load overrides a same-cycle drain
   always_comb begin
      data1_d  = data1_q;
      valid1_d = valid1_q;
      if (drain1) begin
         valid1_d = 1'b0;
      end
      if (load1) begin
         valid1_d = 1'b1;
         data1_d  = in_data;
      end
   end

   // Burst pointer: only words accepted in auto mode advance it, so leaving
   // and re-entering auto mode resumes the interrupted burst.
   always_comb begin
      rr_ch_d     = rr_ch_q;
      burst_cnt_d = burst_cnt_q;
      if (accept && auto_mode) begin
         if (burst_cnt_q == CNT_LAST) begin
            burst_cnt_d = '0;
            rr_ch_d     = ~rr_ch_q;
         end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
         end
      end
   end

   // busy is registered from the same next-state as the valid flags
   assign busy_d = valid0_d | valid1_d;

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data0_q     <= '0;
         data1_q     <= '0;
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         rr_ch_q     <= 1'b0;
         burst_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         valid0_q    <= valid0_d;
         valid1_q    <= valid1_d;
         rr_ch_q     <= rr_ch_d;
         burst_cnt_q <= burst_cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign out0_data  = data0_q;
   assign out0_valid = valid0_q;
   assign out1_data  = data1_q;
   assign out1_valid = valid1_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_demux2_stream.sv
// ----------------------------------------------------------------------------
// tb_demux2_stream
// Scenario-driven bench for demux2_stream. Each accepted input word is pushed
// onto the expected queue of the channel it should reach; every output
// handshake pops that queue and compares the word.
// ----------------------------------------------------------------------------
module tb_demux2_stream;

   localparam int unsigned SIZE      = 4;
   localparam int unsigned BURST_LEN = 2;

   logic            clk;
   logic            rst_n;
   logic            auto_mode;
   logic            sel;
   logic [SIZE-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] out0_data;
   logic            out0_valid;
   logic            out0_ready;
   logic [SIZE-1:0] out1_data;
   logic            out1_valid;
   logic            out1_ready;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [SIZE-1:0] q0[$];
   logic [SIZE-1:0] q1[$];

   demux2_stream #(.SIZE(SIZE), .BURST_LEN(BURST_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .auto_mode  (auto_mode),
      .sel        (sel),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: at the falling edge note input acceptance and score every
   // output handshake, then step past the rising edge.
   task automatic cycle(output bit acc);
      logic [SIZE-1:0] e;
      @(negedge clk);
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
         n_checks++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL ch0_extra: got word %0d, required no word", out0_data);
         end else begin
            e = q0.pop_front();
            if (out0_data !== e) begin
               n_fail++;
               $display("FAIL ch0_data: got %0d, required %0d", out0_data, e);
            end
         end
      end
      if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
         n_checks++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL ch1_extra: got word %0d, required no word", out1_data);
         end else begin
            e = q1.pop_front();
            if (out1_data !== e) begin
               n_fail++;
               $display("FAIL ch1_data: got %0d, required %0d", out1_data, e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      repeat (n) cycle(acc);
   endtask

   // Offer one word until accepted (bounded) and record where it must appear
   task automatic send(input bit ch, input logic [SIZE-1:0] d, input logic s,
                       output int waits);
      bit acc;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = d;
      sel      = s;
      cycle(acc);
      while (!acc && waits < 20) begin
         waits++;
         cycle(acc);
      end
      in_valid = 1'b0;
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send_timeout: word %0d not accepted after %0d cycles", d, waits);
      end else if (ch) begin
         q1.push_back(d);
      end else begin
         q0.push_back(d);
      end
   endtask

   // Send and require acceptance without any stall cycle
   task automatic send_imm(input bit ch, input logic [SIZE-1:0] d, input logic s);
      int waits;
      send(ch, d, s, waits);
      n_checks++;
      if (waits != 0) begin
         n_fail++;
         $display("FAIL in_ready_stall: word %0d waited %0d cycles, required 0", d, waits);
      end
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drained: pending ch0=%0d ch1=%0d valids=%b%b, required all empty",
                  name, q0.size(), q1.size(), out0_valid, out1_valid);
      end
   endtask

   task automatic pulse_reset();
      bit acc;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      cycle(acc);
      rst_n = 1'b1;
      q0.delete();
      q1.delete();
   endtask

   task automatic test_reset();
      bit acc;
      rst_n      = 1'b0;
      auto_mode  = 1'b0;
      sel        = 1'b0;
      in_valid   = 1'b1;
      in_data    = 4'd5;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      cycle(acc);
      cycle(acc);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      n_checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b%b, required 00", out0_valid, out1_valid);
      end
      n_checks++;
      if (out0_data !== 4'd0 || out1_data !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %0d/%0d, required 0/0", out0_data, out1_data);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_explicit();
      auto_mode  = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      send_imm(1'b0, 4'd1, 1'b0);
      n_checks++;
      if (out0_valid !== 1'b1 || out0_data !== 4'd1) begin
         n_fail++;
         $display("FAIL explicit_ch0: got valid %b data %0d, required 1/1", out0_valid, out0_data);
      end
      send_imm(1'b1, 4'd2, 1'b1);
      n_checks++;
      if (out1_valid !== 1'b1 || out1_data !== 4'd2) begin
         n_fail++;
         $display("FAIL explicit_ch1: got valid %b data %0d, required 1/2", out1_valid, out1_data);
      end
      send_imm(1'b0, 4'd1, 1'b0);
      send_imm(1'b1, 4'd2, 1'b1);
      send_imm(1'b0, 4'd1, 1'b0);
      send_imm(1'b1, 4'd3, 1'b1);
      idle(3);
      check_drained("explicit");
   endtask

   task automatic test_auto_burst();
      bit exp_ch[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      auto_mode  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         // sel is driven opposite to the burst target to show it is ignored
         send_imm(exp_ch[i], SIZE'(i + 1), ~exp_ch[i]);
      end
      idle(3);
      check_drained("auto_burst");
   endtask

   task automatic test_backpressure();
      bit acc;
      auto_mode  = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b1;
      send_imm(1'b0, 4'd7, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'd8;
      sel      = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_in_ready: got %b, required 0", in_ready);
      end
      cycle(acc);
      cycle(acc);
      n_checks++;
      if (acc !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 4'd7 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: got acc %b valid %b data %0d busy %b, required 0/1/7/1",
                  acc, out0_valid, out0_data, busy);
      end
      out0_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b, required 1", in_ready);
      end
      cycle(acc);
      in_valid = 1'b0;
      n_checks++;
      if (acc !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_reload_accept: got %b, required 1", acc);
      end else begin
         q0.push_back(4'd8);
      end
      n_checks++;
      if (out0_valid !== 1'b1 || out0_data !== 4'd8) begin
         n_fail++;
         $display("FAIL bp_reload: got valid %b data %0d, required 1/8", out0_valid, out0_data);
      end
      idle(3);
      check_drained("backpressure");
   endtask

   task automatic test_mode_interrupt();
      pulse_reset();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      auto_mode  = 1'b1;
      send_imm(1'b0, 4'd9, 1'b1);
      auto_mode = 1'b0;
      send_imm(1'b1, 4'd10, 1'b1);
      send_imm(1'b1, 4'd11, 1'b1);
      auto_mode = 1'b1;
      send_imm(1'b0, 4'd12, 1'b1);
      send_imm(1'b1, 4'd13, 1'b0);
      send_imm(1'b1, 4'd14, 1'b0);
      idle(3);
      check_drained("mode_interrupt");
   endtask

   task automatic test_reset_mid();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      auto_mode  = 1'b1;
      // Two auto words complete a burst, leaving the pointer on channel 1
      send_imm(1'b0, 4'd1, 1'b0);
      send_imm(1'b0, 4'd2, 1'b0);
      idle(2);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      auto_mode  = 1'b0;
      send_imm(1'b0, 4'd4, 1'b0);
      send_imm(1'b1, 4'd5, 1'b1);
      n_checks++;
      if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_fill: got valids %b%b, required 11", out0_valid, out1_valid);
      end
      pulse_reset();
      n_checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got valids %b%b busy %b, required 00/0",
                  out0_valid, out1_valid, busy);
      end
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      auto_mode  = 1'b1;
      send_imm(1'b0, 4'd6, 1'b1);
      send_imm(1'b0, 4'd7, 1'b1);
      send_imm(1'b1, 4'd8, 1'b0);
      idle(3);
      check_drained("reset_mid");
   endtask

   initial begin
      rst_n      = 1'b0;
      auto_mode  = 1'b0;
      sel        = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      test_reset();
      test_explicit();
      test_auto_burst();
      test_backpressure();
      test_mode_interrupt();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
